uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//   UART 8N1 transmitter with an integrated byte FIFO; upstream stage of uart_rx.
//   Accepts bytes on a valid/ready interface, buffers up to FIFO_DEPTH bytes, and
//   serialises them LSB-first onto o_tx_serial at BAUD_RATE.
//   Back-to-back frames are sent with no idle gap while the FIFO holds data.
// PARAMETERS
//   CLK_RATE    100_000_000  input clock frequency, Hz
//   BAUD_RATE   9600         serial bit rate, bits/s
//   FIFO_DEPTH  16           byte FIFO entries; power of two, >= 2
//   (local) NCLKS_PER_BIT = CLK_RATE / BAUD_RATE, integer division; CW = $clog2(FIFO_DEPTH)+1
// PORTS
//   clk           in   1   system clock
//   rst           in   1   asynchronous reset, active-high
//   i_tx_data     in   8   byte to transmit
//   i_tx_valid    in   1   i_tx_data valid
//   o_tx_ready    out  1   FIFO not full; byte accepted on posedge when valid && ready
//   o_tx_serial   out  1   UART line, idle high
//   o_tx_busy     out  1   high while a frame (start..stop) is on the line
//   o_fifo_count  out  CW  bytes currently buffered (0..FIFO_DEPTH)
// BEHAVIOUR
//   Reset (async assert, sync-to-clk release): o_tx_serial=1, o_tx_busy=0, o_tx_ready=1,
//     o_fifo_count=0, FSM=IDLE, FIFO pointers and bit/clock counters cleared.
//   Reset mid-frame: line returns high immediately, frame aborted, buffered bytes dropped.
//   FIFO: push on valid && ready; o_tx_ready = (count != FIFO_DEPTH), registered-count based.
//     Full: push blocked even if a pop occurs in the same cycle (no write-through when full).
//     Empty: no bypass; byte always passes through FIFO. Simultaneous push+pop when not full
//     or empty: count unchanged. Pointers wrap modulo FIFO_DEPTH.
//   i_tx_data ignored when i_tx_valid=0 or o_tx_ready=0.
//   FSM states IDLE, START, DATA, STOP; clock counter counts 0..NCLKS_PER_BIT-1 per bit.
//     IDLE : line=1, busy=0. If FIFO non-empty: pop into shift reg, -> START.
//     START: line=0 for NCLKS_PER_BIT cycles, -> DATA with bit index 0.
//     DATA : line=shift[0] for NCLKS_PER_BIT cycles per bit, shift right, 8 bits, -> STOP.
//     STOP : line=1 for NCLKS_PER_BIT cycles. At last cycle: if FIFO non-empty, pop and
//            -> START directly (no idle cycle); else -> IDLE.
//   Latency: byte pushed at edge N into empty FIFO with FSM IDLE -> pop at edge N+1,
//     o_tx_serial low from edge N+1. Frame length exactly 10*NCLKS_PER_BIT cycles.
//   o_tx_busy high in START/DATA/STOP, registered with the state.
//   o_tx_serial driven from a flop (glitch-free).
//   Bytes transmitted in push order; no byte lost or duplicated unless reset intervenes.
// TESTING  (CLK_RATE=100MHz, BAUD_RATE=9600 -> NCLKS_PER_BIT=10416 unless noted)
//   1. Single byte 0xA5 pushed after reset -> line low 1 cycle after accept;
//      bits 1,0,1,0,0,1,0,1 each 10416 cycles; stop high; busy falls after 104160 cycles.
//   2. Loopback o_tx_serial -> uart_rx: 20 random bytes pushed back-to-back ->
//      uart_rx reports all 20 in order; exactly 10*10416 cycles between frame starts.
//   3. FIFO_DEPTH=4: push 6 bytes with valid held high -> ready drops when count=4
//      (1 byte already popped to shifter); all 6 bytes (0x00,0xFF,0x55,0xAA,0x01,0x80)
//      sent in order.
//   4. Push 0x3C at the same edge a pop occurs with count=1 -> count stays 1;
//      0x3C sent after current byte.
//   5. Assert rst mid DATA of 0x96 with 3 bytes queued -> line=1 immediately, count=0,
//      ready=1; after release, new byte 0x12 sent as a clean frame.
//   6. BAUD_RATE=CLK_RATE/4 (NCLKS_PER_BIT=4): byte 0x81 -> each bit exactly 4 cycles;
//      count wraps correctly over 2*FIFO_DEPTH pushes.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Byte push channel into the UART transmitter FIFO.
// Producer drives data/valid, transmitter answers with ready.
interface uart_tx_fifo_if;
    logic [7:0] i_tx_data;
    logic       i_tx_valid;
    logic       o_tx_ready;

    modport master (
        output i_tx_data,
        output i_tx_valid,
        input  o_tx_ready
    );

    modport slave (
        input  i_tx_data,
        input  i_tx_valid,
        output o_tx_ready
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter with an integrated byte FIFO.
// Frames are sent back-to-back while the FIFO holds data.
module uart_tx_fifo #(
    parameter int CLK_RATE   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_tx_fifo_if.slave               tx,
    output logic                        o_tx_serial,
    output logic                        o_tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);
    localparam int NCLKS = CLK_RATE / BAUD_RATE;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int CKW   = (NCLKS > 1) ? $clog2(NCLKS) : 1;

    localparam logic [CW-1:0]  FULL    = CW'(FIFO_DEPTH);
    localparam logic [CKW-1:0] CK_LAST = CKW'(NCLKS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [1:0]     state_q, state_d;
    logic [CKW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           serial_q, serial_d;
    logic           busy_q, busy_d;

    logic push;
    logic pop;
    logic ready;
    logic non_empty;
    logic last_clk;

    // Ready comes from the registered count, so a full FIFO never
    // accepts a byte even when the shifter pops in the same cycle.
    assign ready     = (count_q != FULL);
    assign push      = tx.i_tx_valid && ready;
    assign non_empty = (count_q != '0);
    assign last_clk  = (clk_cnt_q == CK_LAST);

    assign tx.o_tx_ready = ready;
    assign o_tx_serial   = serial_q;
    assign o_tx_busy     = busy_q;
    assign o_fifo_count  = count_q;

    // FIFO storage; contents need no reset, the pointers qualify them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx.i_tx_data;
        end
    end

    // Frame sequencer: the line value is decided one cycle ahead so the
    // serial output can come straight from a flop.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        serial_d  = serial_q;
        busy_d    = busy_q;
        pop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                serial_d  = 1'b1;
                busy_d    = 1'b0;
                clk_cnt_d = '0;
                if (non_empty) begin
                    pop      = 1'b1;
                    shift_d  = mem_q[rd_ptr_q];
                    state_d  = START;
                    serial_d = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            START: begin
                if (last_clk) begin
                    clk_cnt_d = '0;
                    bit_d     = 3'd0;
                    state_d   = DATA;
                    serial_d  = shift_q[0];
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (last_clk) begin
                    clk_cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d  = STOP;
                        serial_d = 1'b1;
                    end else begin
                        bit_d    = bit_q + 1'b1;
                        shift_d  = {1'b0, shift_q[7:1]};
                        serial_d = shift_q[1];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (last_clk) begin
                    clk_cnt_d = '0;
                    if (non_empty) begin
                        pop      = 1'b1;
                        shift_d  = mem_q[rd_ptr_q];
                        state_d  = START;
                        serial_d = 1'b0;
                    end else begin
                        state_d  = IDLE;
                        serial_d = 1'b1;
                        busy_d   = 1'b0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                serial_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    // FIFO bookkeeping; pointers wrap naturally at the power-of-two depth.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset drops the line high and discards the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            busy_q    <= busy_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 4 clocks per bit, depth 4.
// Every line cycle of each frame is compared to the expected bit.
module tb_uart_tx_fifo;
    localparam int NCLK  = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_serial;
    logic          tx_busy;
    logic [CW-1:0] fifo_count;

    uart_tx_fifo_if bus ();

    uart_tx_fifo #(
        .CLK_RATE   (100),
        .BAUD_RATE  (25),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tx           (bus),
        .o_tx_serial  (tx_serial),
        .o_tx_busy    (tx_busy),
        .o_fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] pq[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (tx_serial === 1'b0) seen = 1'b1;
        end
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    // Called in the first cycle of a frame (start bit just driven).
    task automatic check_frame(input string tag, input logic [7:0] b);
        logic [9:0] f;
        int good;
        int busy_n;
        f = {1'b1, b, 1'b0};
        busy_n = 0;
        for (int k = 0; k < 10; k++) begin
            good = 0;
            for (int c = 0; c < NCLK; c++) begin
                if (tx_serial === f[k]) good++;
                if (tx_busy === 1'b1) busy_n++;
                tick();
            end
            check($sformatf("%s_bit%0d", tag, k), good, NCLK);
        end
        check({tag, "_busy"}, busy_n, 10 * NCLK);
    endtask

    task automatic push_all(input string tag);
        logic acc;
        for (int i = 0; i < pq.size(); i++) begin
            bus.i_tx_valid = 1'b1;
            bus.i_tx_data  = pq[i];
            acc = 1'b0;
            for (int w = 0; w < 500 && !acc; w++) begin
                acc = bus.o_tx_ready;
                tick();
            end
            check($sformatf("%s_acc%0d", tag, i), {31'd0, acc}, 32'd1);
        end
        bus.i_tx_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy0"}, {31'd0, tx_busy}, 32'd0);
        check({tag, "_line1"}, {31'd0, tx_serial}, 32'd1);
        check({tag, "_cnt0"}, {29'd0, fifo_count}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t3 [6];
        logic acc;
        t3 = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80};
        rst = 1'b1;
        bus.i_tx_valid = 1'b0;
        bus.i_tx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_line", {31'd0, tx_serial}, 32'd1);
        check("rst_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_ready", {31'd0, bus.o_tx_ready}, 32'd1);
        check("rst_cnt", {29'd0, fifo_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_idle("post_rst");

        // Single byte 0xA5: start bit one edge after acceptance.
        bus.i_tx_valid = 1'b1;
        bus.i_tx_data  = 8'hA5;
        tick();
        bus.i_tx_valid = 1'b0;
        check("t1_cnt1", {29'd0, fifo_count}, 32'd1);
        check("t1_line_hi", {31'd0, tx_serial}, 32'd1);
        tick();
        check("t1_line_lo", {31'd0, tx_serial}, 32'd0);
        check("t1_busy", {31'd0, tx_busy}, 32'd1);
        check("t1_cnt0", {29'd0, fifo_count}, 32'd0);
        check_frame("t1", 8'hA5);
        check_idle("t1_end");
        repeat (3) tick();

        // Depth 4, valid held: full at count 4, data ignored while full.
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    bus.i_tx_valid = 1'b1;
                    bus.i_tx_data  = t3[i];
                    tick();
                end
                check("t3_cnt_full", {29'd0, fifo_count}, 32'd4);
                check("t3_rdy_full", {31'd0, bus.o_tx_ready}, 32'd0);
                bus.i_tx_data = 8'hEE;
                repeat (10) tick();
                check("t3_still_full", {29'd0, fifo_count}, 32'd4);
                bus.i_tx_data = t3[5];
                acc = 1'b0;
                for (int w = 0; w < 500 && !acc; w++) begin
                    acc = bus.o_tx_ready;
                    tick();
                end
                bus.i_tx_valid = 1'b0;
                check("t3_acc_last", {31'd0, acc}, 32'd1);
            end
            begin
                wait_start("t3_start");
                for (int i = 0; i < 6; i++)
                    check_frame($sformatf("t3_f%0d", i), t3[i]);
            end
        join
        check_idle("t3_end");
        repeat (3) tick();

        // Push coinciding with a pop at count 1 leaves count at 1.
        bus.i_tx_valid = 1'b1;
        bus.i_tx_data  = 8'h5A;
        tick();
        bus.i_tx_data  = 8'h3C;
        tick();
        bus.i_tx_valid = 1'b0;
        check("t4_cnt_same", {29'd0, fifo_count}, 32'd1);
        check("t4_line_lo", {31'd0, tx_serial}, 32'd0);
        check_frame("t4_a", 8'h5A);
        check("t4_no_gap", {31'd0, tx_serial}, 32'd0);
        check_frame("t4_b", 8'h3C);
        check_idle("t4_end");
        repeat (3) tick();

        // Reset in the data phase of 0x96 with three bytes queued.
        pq = '{8'h96, 8'h11, 8'h22, 8'h33};
        push_all("t5");
        check("t5_cnt3", {29'd0, fifo_count}, 32'd3);
        repeat (3) tick();
        check("t5_mid_data", {31'd0, tx_serial}, 32'd0);
        check("t5_mid_busy", {31'd0, tx_busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("t5_rst_line", {31'd0, tx_serial}, 32'd1);
        check("t5_rst_busy", {31'd0, tx_busy}, 32'd0);
        check("t5_rst_cnt", {29'd0, fifo_count}, 32'd0);
        check("t5_rst_rdy", {31'd0, bus.o_tx_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();
        check_idle("t5_rel");
        bus.i_tx_valid = 1'b1;
        bus.i_tx_data  = 8'h12;
        tick();
        bus.i_tx_valid = 1'b0;
        tick();
        check("t5_new_lo", {31'd0, tx_serial}, 32'd0);
        check_frame("t5_new", 8'h12);
        check_idle("t5_end");
        repeat (3) tick();

        // 0x81 then seven more: 2*DEPTH pushes wrap the pointers.
        pq = '{8'h81, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};
        fork
            push_all("t6");
            begin
                wait_start("t6_start");
                for (int i = 0; i < 8; i++)
                    check_frame($sformatf("t6_f%0d", i), pq[i]);
            end
        join
        check_idle("t6_end");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
